// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and opcode constants for the fetch sequencer
package fetch_pkg;
  typedef logic [15:0] pc_t;
  typedef enum logic [1:0] {RUN, STALL, FAULT} state_t;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;
endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack with saturating occupancy count
module return_addr_stack
  import fetch_pkg::*;
#(
  parameter int RAS_DEPTH = 8,
  parameter int RAS_PTR_W = $clog2(RAS_DEPTH)
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  pc_t  push_data,
  output pc_t  pop_data,
  output logic empty,
  output logic full
);
  pc_t mem [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ptr, top;
  logic [RAS_PTR_W:0] count;
  assign top = ptr - RAS_PTR_W'(1);
  assign pop_data = mem[top];
  assign empty = count == '0;
  assign full = count == (RAS_PTR_W+1)'(RAS_DEPTH);
  // When full, ptr already points at the oldest entry, so a push overwrites it.
  always_ff @(posedge clock)
    if (push) mem[ptr] <= push_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + RAS_PTR_W'(1);
      count <= full ? count : count + (RAS_PTR_W+1)'(1);
    end else if (pop && !empty) begin
      ptr <= top;
      count <= count - (RAS_PTR_W+1)'(1);
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer with JMP/CALL/RET pre-decode, return-address stack and redirects
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC = 16'h0000,
  parameter int RAS_DEPTH = 8,
  parameter int RAS_PTR_W = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] address,
  output logic        im_enable,
  output logic        instr_valid,
  output logic        ras_overflow,
  output logic        fault
);
  state_t state, state_nx;
  pc_t pc, pc_nx, pop_data, target;
  logic [3:0] opcode;
  logic active, is_ret, push, pop, ret_fault, empty, full;
  assign opcode = instruction[15:12];
  assign target = {pc[15:12], instruction[11:0]};
  assign active = state != FAULT;
  assign address = pc;
  assign fault = state == FAULT;
  // STALL with stall low behaves as RUN, so the held word is decoded exactly once.
  assign im_enable = active & ~stall & ~reset;
  assign instr_valid = im_enable & ~branch_taken;
  assign is_ret = instr_valid & (opcode == OP_RET);
  assign push = instr_valid & (opcode == OP_CALL);
  assign pop = is_ret & ~empty;
  assign ret_fault = is_ret & empty;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    if (active) begin
      state_nx = branch_taken ? RUN : stall ? STALL : ret_fault ? FAULT : RUN;
      pc_nx = branch_taken ? branch_target :
              (stall || ret_fault) ? pc :
              (opcode == OP_JMP || push) ? target :
              pop ? pop_data : pc + 16'd1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      pc <= RESET_PC;
      ras_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      if (push && full) ras_overflow <= 1'b1;
    end
  end
  return_addr_stack #(.RAS_DEPTH(RAS_DEPTH), .RAS_PTR_W(RAS_PTR_W)) u_ras (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .push_data(pc + 16'd1),
    .pop_data(pop_data),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, hand sequences and randomized model comparison
module tb_fetch_sequencer;
  typedef struct packed {
    logic [2:0]  ctl;
    logic [15:0] tgt;
    logic [15:0] addr;
    logic [2:0]  ex;
  } vec_t;
  logic clock = 1'b0;
  logic reset, stall, branch_taken;
  logic [15:0] branch_target, instruction, address, held;
  logic im_enable, instr_valid, ras_overflow, fault;
  logic [15:0] address2, instruction2;
  logic im_enable2, instr_valid2, ras_overflow2, fault2;
  logic [15:0] mem [256];
  logic [15:0] m_pc;
  logic [15:0] m_ras [$];
  logic m_fault, m_ovf;
  int checks, errors;
  vec_t tbl [21];
  always #5 clock = ~clock;
  always @(posedge clock) if (im_enable) held <= mem[address[7:0]];
  assign instruction = im_enable ? mem[address[7:0]] : held;
  assign instruction2 = mem[address2[7:0]];
  fetch_sequencer dut (
    .clock(clock), .reset(reset), .instruction(instruction), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .address(address),
    .im_enable(im_enable), .instr_valid(instr_valid), .ras_overflow(ras_overflow), .fault(fault)
  );
  fetch_sequencer #(.RESET_PC(16'hFFFF)) dut2 (
    .clock(clock), .reset(reset), .instruction(instruction2), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .address(address2),
    .im_enable(im_enable2), .instr_valid(instr_valid2), .ras_overflow(ras_overflow2), .fault(fault2)
  );
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask
  task automatic model_step;
    logic [15:0] w;
    if (reset) begin
      m_pc = 16'h0000;
      m_ras.delete();
      m_fault = 1'b0;
      m_ovf = 1'b0;
    end else if (!m_fault) begin
      w = mem[m_pc[7:0]];
      if (branch_taken) m_pc = branch_target;
      else if (!stall) begin
        case (w[15:12])
          4'hC: m_pc = {m_pc[15:12], w[11:0]};
          4'hD: begin
            m_ras.push_back(m_pc + 16'd1);
            if (m_ras.size() > 8) begin
              void'(m_ras.pop_front());
              m_ovf = 1'b1;
            end
            m_pc = {m_pc[15:12], w[11:0]};
          end
          4'hE: if (m_ras.size() == 0) m_fault = 1'b1; else m_pc = m_ras.pop_back();
          default: m_pc = m_pc + 16'd1;
        endcase
      end
    end
  endtask
  task automatic drive(input logic r, input logic s, input logic b, input logic [15:0] t);
    reset = r;
    stall = s;
    branch_taken = b;
    branch_target = t;
    @(negedge clock);
  endtask
  task automatic adv;
    model_step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    logic [15:0] exp_a;
    logic r, s, b, en;
    checks = 0;
    errors = 0;
    held = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[1] = 16'hD005;
    mem[3] = 16'hC008;
    mem[5] = 16'hE000;
    // ctl = {reset, stall, branch_taken}; ex = {im_enable, instr_valid, fault}
    tbl = '{
      {3'b100, 16'h0000, 16'h0000, 3'b000}, {3'b000, 16'h0000, 16'h0000, 3'b110},
      {3'b000, 16'h0000, 16'h0001, 3'b110}, {3'b000, 16'h0000, 16'h0005, 3'b110},
      {3'b000, 16'h0000, 16'h0002, 3'b110}, {3'b000, 16'h0000, 16'h0003, 3'b110},
      {3'b010, 16'h0000, 16'h0008, 3'b000}, {3'b010, 16'h0000, 16'h0008, 3'b000},
      {3'b011, 16'h0040, 16'h0008, 3'b000}, {3'b000, 16'h0000, 16'h0040, 3'b110},
      {3'b010, 16'h0000, 16'h0041, 3'b000}, {3'b010, 16'h0000, 16'h0041, 3'b000},
      {3'b010, 16'h0000, 16'h0041, 3'b000}, {3'b000, 16'h0000, 16'h0041, 3'b110},
      {3'b001, 16'h0005, 16'h0042, 3'b100}, {3'b000, 16'h0000, 16'h0005, 3'b110},
      {3'b000, 16'h0000, 16'h0005, 3'b001}, {3'b011, 16'h0000, 16'h0005, 3'b001},
      {3'b100, 16'h0000, 16'h0005, 3'b001}, {3'b000, 16'h0000, 16'h0000, 3'b110},
      {3'b000, 16'h0000, 16'h0001, 3'b110}
    };
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    adv();
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0], tbl[i].tgt);
      chk("tbl_address", address, tbl[i].addr);
      chk1("tbl_im_enable", im_enable, tbl[i].ex[2]);
      chk1("tbl_instr_valid", instr_valid, tbl[i].ex[1]);
      chk1("tbl_fault", fault, tbl[i].ex[0]);
      chk1("tbl_ras_overflow", ras_overflow, 1'b0);
      if (i < 3) chk("reset_pc_wrap", address2, i == 2 ? 16'h0000 : 16'hFFFF);
      adv();
    end
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int k = 0; k < 9; k++) begin
      mem[8'h10 + 8'(2 * k)] = 16'hD000 | 16'(8'h12 + 2 * k);
      mem[8'h11 + 8'(2 * k)] = 16'hE000;
    end
    mem[8'h22] = 16'hE000;
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    adv();
    drive(1'b0, 1'b0, 1'b1, 16'h0010);
    adv();
    for (int k = 0; k < 18; k++) begin
      exp_a = k < 9 ? 16'(16 + 2 * k) : k == 9 ? 16'h0022 : 16'(33 - 2 * (k - 10));
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("nest_address", address, exp_a);
      chk1("nest_ras_overflow", ras_overflow, k > 8);
      chk1("nest_fault", fault, 1'b0);
      adv();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, k == 1, 16'h0000);
      chk1("underflow_fault", fault, 1'b1);
      chk1("underflow_im_enable", im_enable, 1'b0);
      chk("underflow_frozen", address, 16'h0013);
      adv();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    adv();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    chk1("after_reset_fault", fault, 1'b0);
    chk1("after_reset_overflow", ras_overflow, 1'b0);
    mem[0] = 16'hE000;
    chk("ret0_address", address, 16'h0000);
    chk1("ret0_im_enable", im_enable, 1'b1);
    adv();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    chk1("ret0_fault", fault, 1'b1);
    chk1("ret0_im_enable_off", im_enable, 1'b0);
    adv();
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    adv();
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    chk1("ret0_cleared", fault, 1'b0);
    chk("ret0_reset_pc", address, 16'h0000);
    adv();
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 9))
        0: mem[i] = 16'hC000 | 16'($urandom_range(0, 4095));
        1, 2: mem[i] = 16'hD000 | 16'($urandom_range(0, 4095));
        3, 4: mem[i] = 16'hE000;
        default: mem[i] = 16'($urandom_range(0, 16'hBFFF));
      endcase
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    adv();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99) < 2 || (m_fault && $urandom_range(0, 9) == 0);
      s = $urandom_range(0, 99) < 20;
      b = $urandom_range(0, 99) < 8;
      drive(r, s, b, 16'($urandom));
      en = !r && !m_fault && !s;
      chk("rnd_address", address, m_pc);
      chk1("rnd_im_enable", im_enable, en);
      chk1("rnd_instr_valid", instr_valid, en && !b);
      chk1("rnd_fault", fault, m_fault);
      chk1("rnd_ras_overflow", ras_overflow, m_ovf);
      adv();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter sequencer and controller for the 16-bit, 256-entry instruction memory, which has an asynchronous read gated by an enable.
- Drives the memory address and enable each cycle and pre-decodes the returned word for JMP, CALL and RET.
- Keeps a hardware return-address stack (RAS) and accepts branch redirects and stalls from later pipeline stages.
- Sits between the instruction memory and the decode stage.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
RAS_DEPTH, 8, number of return-address stack entries (power of 2, at least 2)
RAS_PTR_W, 3, log2(RAS_DEPTH)

Ports:
clock  input  1  system clock, all state updates on the rising edge
reset  input  1  synchronous, active-high reset
instruction  input  16  word returned by instruction memory for the current address (same cycle)
stall  input  1  decode/execute back-pressure; hold PC
branch_taken  input  1  execute stage resolved a taken branch this cycle
branch_target  input  16  absolute redirect address, valid with branch_taken
address  output  16  instruction memory address (equals the PC register)
im_enable  output  1  instruction memory enable
instr_valid  output  1  instruction on the bus is a valid, non-squashed fetch for decode
ras_overflow  output  1  sticky: CALL was issued while the RAS was full
fault  output  1  RET was issued while the RAS was empty; sequencer is halted

Behaviour:
- One clock domain: clock. reset is synchronous and active-high.
- Reset values on the cycle after reset is sampled high:
  - PC = RESET_PC, state = RUN, RAS pointer = 0, RAS count = 0.
  - ras_overflow = 0, fault = 0.
- While reset is high: im_enable = 0, instr_valid = 0.
- States:
  - RUN: normal fetch.
  - STALL: PC held.
  - FAULT: halted; exited only by reset.
- Combinational outputs:
  - address = PC.
  - im_enable = 1 in RUN with stall = 0; otherwise 0. When im_enable = 0 the memory holds its last word.
  - instr_valid = im_enable & ~branch_taken.
- Opcode is instruction[15:12]: 1100 = JMP, 1101 = CALL, 1110 = RET. All other opcodes are sequential.
- Jump target is {PC[15:12], instruction[11:0]}.
- Next-PC priority, evaluated in RUN/STALL, highest first:
  1. branch_taken: PC <- branch_target; no RAS action; state <- RUN, even if stall is high.
  2. stall: PC held; state <- STALL; no decode or RAS action.
  3. JMP: PC <- target.
  4. CALL: push PC+1, then PC <- target.
  5. RET with RAS non-empty: pop, PC <- popped value.
  6. RET with RAS empty: state <- FAULT, fault <- 1, PC held.
  7. Otherwise: PC <- PC+1.
- Zero-cycle redirect: instruction memory is combinational, so the JMP/CALL/RET target is fetched in the very next cycle.
- STALL -> RUN when stall falls. The held instruction is re-decoded in the first RUN cycle, so it is never decoded twice and never lost.
- PC arithmetic is modulo 2^16: 16'hFFFF + 1 = 16'h0000. The RAS stores full 16-bit values.
- RAS is circular. Push writes entry [ptr] then increments ptr. Pop decrements ptr then reads. Count saturates at RAS_DEPTH.
- CALL with count = RAS_DEPTH:
  - Oldest entry is overwritten, count stays at RAS_DEPTH.
  - ras_overflow <- 1 (sticky until reset).
  - The jump still happens.
- FAULT: im_enable = 0, PC frozen; branch_taken and stall are ignored.
- Reset mid-operation, including in FAULT or STALL, returns all state to reset values on the next edge.

Decomposition:
- Shared package fetch_pkg holds:
  - opcode constants OP_JMP = 4'b1100, OP_CALL = 4'b1101, OP_RET = 4'b1110;
  - the state encoding RUN / STALL / FAULT;
  - a 16-bit pc_t typedef.
- One sub-module: return_addr_stack, parameterised by RAS_DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: pop_data, empty, full.
  - Synchronous reset.
- The sequencer owns the FSM, the next-PC mux and the sticky flags.

Test Plan:
- Reset then free-run, memory filled with 16'h0000 -> address 0,1,2,3 on successive cycles; im_enable = 1; instr_valid = 1.
- Word at 1 = 16'hD005 (CALL 5), word at 5 = 16'hE000 (RET) -> address sequence 1, 5, 2; RAS count 1 -> 0; fault stays 0.
- stall held 3 cycles at PC = 4 -> address stays 4; im_enable = 0; instr_valid = 0; PC = 5 on the first cycle after stall falls.
- branch_taken = 1, branch_target = 16'h0040, with stall = 1 and a JMP on the bus -> instr_valid = 0 that cycle; next address = 16'h0040.
- Nine nested CALLs with RAS_DEPTH = 8 -> ras_overflow = 1 after the 9th; eight RETs return correctly in LIFO order; the 9th RET gives fault = 1 and im_enable = 0 until reset.
- RESET_PC = 16'hFFFF with a sequential word -> next address 16'h0000.
- RET at PC = 0 after reset -> fault = 1; asserting reset for one cycle clears fault and returns address to RESET_PC.
